// File: rtl/systolic_array_control_unit_if.sv
// Tile-dispatch / buffer / MAC-grid signal bundle for the systolic array controller.
interface systolic_array_control_unit_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned SW = 5
);
  logic          op_valid;
  logic [RW-1:0] op_rows;
  logic          op_ready;
  logic          weight_avail;
  logic          input_avail;
  logic          mac_value_ready;
  logic          weight_rd;
  logic          input_rd;
  logic          weight_en;
  logic          mac_start;
  logic          mac_shift;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic [SW-1:0] step_idx;

  // Dispatch/buffer/grid side: issues ops and reports availability.
  modport master (
    output op_valid, op_rows, weight_avail, input_avail, mac_value_ready,
    input  op_ready, weight_rd, input_rd, weight_en, mac_start, mac_shift,
           out_valid, busy, done, err, step_idx
  );

  // Controller side.
  modport slave (
    input  op_valid, op_rows, weight_avail, input_avail, mac_value_ready,
    output op_ready, weight_rd, input_rd, weight_en, mac_start, mac_shift,
           out_valid, busy, done, err, step_idx
  );
endinterface

// File: rtl/systolic_array_control_unit.sv
// Sequencing controller for an N x N systolic MAC array: weight preload,
// per-wavefront start/wait/shift stepping, buffer read gating and output-row flags.
module systolic_array_control_unit #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_ROWS = 16,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned RW       = $clog2(MAX_ROWS + 1),
  parameter int unsigned SW       = $clog2(MAX_ROWS + 2 * N)
) (
  input  logic i_clk,
  input  logic i_rst,
  systolic_array_control_unit_if.slave io_ctl
);

  localparam int unsigned LW = $clog2(N + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [LW-1:0] LOAD_LAST = LW'(N - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STEP_PAD  = SW'(2 * N - 2);
  localparam logic [SW-1:0] OUT_FIRST = SW'(N - 1);
  localparam logic [RW-1:0] ROWS_MAX  = RW'(MAX_ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [RW-1:0] r_rows;
  logic [LW-1:0] r_load_cnt;
  logic [SW-1:0] r_step;
  logic [WW-1:0] r_wait_cnt;
  logic          r_err;

  logic [SW-1:0] w_rows_ext;
  logic [SW-1:0] w_step_final;
  logic          w_has_input;
  logic          w_step_last;

  logic          w_accept;
  logic          w_load_beat;
  logic          w_issue;
  logic          w_wait_inc;
  logic          w_timeout;
  logic          w_step_adv;

  logic          w_op_ready;
  logic          w_weight_rd;
  logic          w_input_rd;
  logic          w_weight_en;
  logic          w_mac_start;
  logic          w_mac_shift;
  logic          w_out_valid;
  logic          w_done;

  // Step bookkeeping: whether this wavefront consumes a real input row, and last-step detect.
  always_comb begin
    w_rows_ext   = SW'(r_rows);
    w_step_final = w_rows_ext + STEP_PAD - SW'(1);
    w_has_input  = (r_step < w_rows_ext);
    w_step_last  = (r_step == w_step_final);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_load_beat = 1'b0;
    w_issue     = 1'b0;
    w_wait_inc  = 1'b0;
    w_timeout   = 1'b0;
    w_step_adv  = 1'b0;
    w_op_ready  = 1'b0;
    w_weight_rd = 1'b0;
    w_input_rd  = 1'b0;
    w_weight_en = 1'b0;
    w_mac_start = 1'b0;
    w_mac_shift = 1'b0;
    w_out_valid = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_op_ready = 1'b1;
        if (io_ctl.op_valid) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end

      S_LOAD: begin
        w_weight_en = 1'b1;
        if (io_ctl.weight_avail) begin
          w_weight_rd = 1'b1;
          w_mac_shift = 1'b1;
          w_load_beat = 1'b1;
          if (r_load_cnt == LOAD_LAST) begin
            w_next = (r_rows != '0) ? S_START : S_DONE;
          end
        end
      end

      S_START: begin
        // Past the last real row the external skew buffer feeds zeros, so no input is needed.
        if (!(w_has_input && !io_ctl.input_avail)) begin
          w_mac_start = 1'b1;
          w_input_rd  = w_has_input;
          w_issue     = 1'b1;
          w_next      = S_WAIT;
        end
      end

      S_WAIT: begin
        if (io_ctl.mac_value_ready) begin
          w_next = S_SHIFT;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_SHIFT: begin
        w_mac_shift = 1'b1;
        w_out_valid = (r_step >= OUT_FIRST);
        if (w_step_last) begin
          w_next = S_DONE;
        end else begin
          w_step_adv = 1'b1;
          w_next     = S_START;
        end
      end

      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operation registers: row count, preload/step/wait counters and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rows     <= '0;
      r_load_cnt <= '0;
      r_step     <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        // Clamp out-of-range requests so the step count always fits SW bits.
        r_rows     <= (io_ctl.op_rows > ROWS_MAX) ? ROWS_MAX : io_ctl.op_rows;
        r_load_cnt <= '0;
        r_step     <= '0;
        r_err      <= 1'b0;
      end
      if (w_load_beat) begin
        r_load_cnt <= r_load_cnt + LW'(1);
      end
      if (w_issue) begin
        r_wait_cnt <= '0;
      end
      if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_step_adv) begin
        r_step <= r_step + SW'(1);
      end
    end
  end

  assign io_ctl.op_ready  = w_op_ready;
  assign io_ctl.weight_rd = w_weight_rd;
  assign io_ctl.input_rd  = w_input_rd;
  assign io_ctl.weight_en = w_weight_en;
  assign io_ctl.mac_start = w_mac_start;
  assign io_ctl.mac_shift = w_mac_shift;
  assign io_ctl.out_valid = w_out_valid;
  assign io_ctl.done      = w_done;
  assign io_ctl.busy      = (r_state != S_IDLE);
  assign io_ctl.err       = r_err;
  assign io_ctl.step_idx  = r_step;

endmodule

// File: tb/tb_systolic_array_control_unit.sv
// Directed bench for systolic_array_control_unit (N=4, MAX_ROWS=16, TIMEOUT=64).
module tb_systolic_array_control_unit;

  localparam int N    = 4;
  localparam int MAXR = 16;
  localparam int TMO  = 64;
  localparam int RW   = $clog2(MAXR + 1);
  localparam int SW   = $clog2(MAXR + 2 * N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  // 0 weight_rd, 1 input_rd, 2 mac_start, 3 mac_shift, 4 out_valid, 5 done, 6 weight_en, 7 rule breaks
  int   cnt[8] = '{default: 0};
  int   snap[8] = '{default: 0};
  int   t_done = -1;
  int   t_s2 = -1;

  systolic_array_control_unit_if #(.RW(RW), .SW(SW)) bus ();

  systolic_array_control_unit #(
    .N(N),
    .MAX_ROWS(MAXR),
    .TIMEOUT(TMO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_ctl(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and strobe-rule watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.weight_rd) cnt[0] <= cnt[0] + 1;
      if (bus.input_rd)  cnt[1] <= cnt[1] + 1;
      if (bus.mac_start) cnt[2] <= cnt[2] + 1;
      if (bus.mac_shift) cnt[3] <= cnt[3] + 1;
      if (bus.out_valid) cnt[4] <= cnt[4] + 1;
      if (bus.done)      cnt[5] <= cnt[5] + 1;
      if (bus.weight_en) cnt[6] <= cnt[6] + 1;
      if (bus.done) t_done <= cyc;
      if (bus.mac_start && bus.step_idx == SW'(2)) t_s2 <= cyc;
      if ((bus.mac_start && bus.mac_shift) ||
          (bus.weight_rd && !bus.weight_en) ||
          (bus.out_valid && !bus.mac_shift) ||
          (bus.out_valid && bus.step_idx < SW'(N - 1)) ||
          (bus.weight_en && (bus.mac_start || bus.input_rd)) ||
          (bus.busy == bus.op_ready))
        cnt[7] <= cnt[7] + 1;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < 8; i++) snap[i] = cnt[i];
  endtask

  task automatic cnts(input string tag, input int wrd, input int ird, input int st,
                      input int sh, input int ov, input int wen);
    chkn({tag, "_weight_rd"}, cnt[0] - snap[0], wrd);
    chkn({tag, "_input_rd"},  cnt[1] - snap[1], ird);
    chkn({tag, "_mac_start"}, cnt[2] - snap[2], st);
    chkn({tag, "_mac_shift"}, cnt[3] - snap[3], sh);
    chkn({tag, "_out_valid"}, cnt[4] - snap[4], ov);
    chkn({tag, "_done_cnt"},  cnt[5] - snap[5], 1);
    chkn({tag, "_weight_en"}, cnt[6] - snap[6], wen);
  endtask

  // One-cycle op_valid; t0 is the accept cycle.
  task automatic start_op(input int m, output int t0);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op_rows  = RW'(m);
    t0 = cyc;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  // mode 0: ready high; 1: ready low for 2 WAIT cycles per step; 2: ready stuck low from step 2.
  task automatic wait_done(input int mode, input int budget);
    int low;
    bit seen;
    low  = 0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      if (mode == 1) begin
        if (bus.mac_start) begin
          bus.mac_value_ready = 1'b0;
          low = 3;
        end else if (low > 0) begin
          low--;
          if (low == 0) bus.mac_value_ready = 1'b1;
        end
      end else if (mode == 2) begin
        if (bus.mac_start && bus.step_idx == SW'(2)) bus.mac_value_ready = 1'b0;
      end
    end
    bus.mac_value_ready = 1'b1;
    #1;
    chk1("done_seen", seen, 1'b1);
  endtask

  initial begin
    int t0;
    int t1;
    bit hit;

    bus.op_valid        = 1'b0;
    bus.op_rows         = '0;
    bus.weight_avail    = 1'b1;
    bus.input_avail     = 1'b1;
    bus.mac_value_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_op_ready", bus.op_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_weight_en", bus.weight_en, 1'b0);
    chk1("rst_mac_shift", bus.mac_shift, 1'b0);
    chkn("rst_step_idx", int'(bus.step_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("idle_op_ready", bus.op_ready, 1'b1);

    // Basic tile M=4: S=10, done at t0+35
    take_snap();
    start_op(4, t0);
    wait_done(0, 200);
    chkn("basic_latency", t_done - t0, 35);
    chkn("basic_last_step", int'(bus.step_idx), 9);
    cnts("basic", 4, 4, 10, 14, 7, 4);

    // Stalls: weight_avail low t0+2..t0+4, input_avail low at step 1 START (t0+11..t0+12)
    take_snap();
    start_op(4, t0);
    @(posedge clk); #1;
    bus.weight_avail = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("wstall_rd", bus.weight_rd, 1'b0);
      chk1("wstall_shift", bus.mac_shift, 1'b0);
      chk1("wstall_en", bus.weight_en, 1'b1);
      @(posedge clk); #1;
    end
    bus.weight_avail = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.input_avail = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("istall_start", bus.mac_start, 1'b0);
      chk1("istall_rd", bus.input_rd, 1'b0);
      chkn("istall_step", int'(bus.step_idx), 1);
      @(posedge clk); #1;
    end
    bus.input_avail = 1'b1;
    wait_done(0, 200);
    chkn("stall_latency", t_done - t0, 40);
    cnts("stall", 4, 4, 10, 14, 7, 7);

    // Slow MAC M=1: S=7, 5 cycles per step
    take_snap();
    start_op(1, t0);
    wait_done(1, 300);
    chkn("slow_latency", t_done - t0, 40);
    cnts("slow", 4, 1, 7, 11, 4, 4);

    // Timeout at step 2, M=4
    take_snap();
    start_op(4, t0);
    wait_done(2, 300);
    chk1("tmo_err", bus.err, 1'b1);
    chkn("tmo_latency", t_done - t0, 76);
    chkn("tmo_wait_span", t_done - t_s2, 65);
    cnts("tmo", 4, 3, 3, 6, 0, 4);
    @(negedge clk);
    chk1("tmo_err_sticky", bus.err, 1'b1);
    chk1("tmo_idle_ready", bus.op_ready, 1'b1);

    // M=0 with op_valid held high: second op accepted the cycle after DONE
    take_snap();
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op_rows  = RW'(0);
    t0 = cyc;
    @(negedge clk);
    chk1("m0_accept_ready", bus.op_ready, 1'b1);
    @(posedge clk); #1;
    bus.op_rows = RW'(2);
    @(negedge clk);
    chk1("m0_err_cleared", bus.err, 1'b0);
    chkn("m0_step_restart", int'(bus.step_idx), 0);
    chk1("m0_busy", bus.busy, 1'b1);
    chk1("m0_op_ready_busy", bus.op_ready, 1'b0);
    hit = 1'b0;
    t1  = -1;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (bus.op_ready && bus.op_valid) begin
        hit = 1'b1;
        t1  = cyc;
      end
    end
    #1;
    chk1("b2b_accept_seen", hit, 1'b1);
    chkn("m0_latency", t_done - t0, 5);
    chkn("b2b_accept_gap", t1 - t0, 6);
    cnts("m0", 4, 0, 0, 4, 0, 4);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    take_snap();
    wait_done(0, 200);
    chkn("b2b_latency", t_done - t1, 29);
    cnts("b2b", 4, 2, 8, 12, 5, 4);

    // Reset while waiting at step 5
    start_op(4, t0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus.mac_start && bus.step_idx == SW'(5)) begin
        bus.mac_value_ready = 1'b0;
        hit = 1'b1;
      end
    end
    chk1("reach_step5", hit, 1'b1);
    repeat (3) @(negedge clk);
    chk1("wait_busy", bus.busy, 1'b1);
    chk1("wait_no_shift", bus.mac_shift, 1'b0);
    take_snap();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mac_value_ready = 1'b1;
    @(negedge clk);
    chk1("mrst_busy", bus.busy, 1'b0);
    chk1("mrst_op_ready", bus.op_ready, 1'b1);
    chk1("mrst_done", bus.done, 1'b0);
    chk1("mrst_err", bus.err, 1'b0);
    chkn("mrst_step", int'(bus.step_idx), 0);
    repeat (3) @(negedge clk);
    #1;
    chkn("mrst_no_done", cnt[5] - snap[5], 0);

    // Normal op after reset, M=3: S=9
    take_snap();
    start_op(3, t0);
    wait_done(0, 200);
    chkn("post_rst_latency", t_done - t0, 32);
    cnts("post_rst", 4, 3, 9, 13, 6, 4);

    chkn("strobe_rules", cnt[7], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_control_unit.md
# systolic_array_control_unit

Sequencing controller for the N×N systolic array of MAC units. It accepts one tile operation at a time and runs the weight preload. It then steps the array through every input wavefront by pulsing the MAC `start`, waiting on the array-wide `value_ready`, and pulsing `MAC_shift`. It gates the weight and input buffer reads and flags valid output rows at the bottom of the array. It sits between the tile dispatch logic and the MAC grid; skew and deskew buffers are external.

## Interface
- N, 4, array dimension (rows = columns)
- MAX_ROWS, 16, maximum input rows per tile
- TIMEOUT, 64, maximum WAIT cycles before error abort
- RW, $clog2(MAX_ROWS+1), width of `op_rows`
- SW, $clog2(MAX_ROWS+2*N), width of the step counter

Ports:
- CLK  in  1  clock; single clock domain
- RST  in  1  reset, synchronous, active-high
- op_valid  in  1  tile operation request
- op_rows  in  RW  input row count M (0..MAX_ROWS), sampled on accept
- op_ready  out  1  high only in IDLE
- weight_avail  in  1  weight buffer holds at least one row
- input_avail  in  1  input buffer holds at least one row
- mac_value_ready  in  1  AND of all MAC `value_ready`
- weight_rd  out  1  pop one weight row
- input_rd  out  1  pop one input row
- weight_en  out  1  MAC input bus selects weights
- mac_start  out  1  MAC `start`, broadcast to the grid
- mac_shift  out  1  MAC `MAC_shift`, broadcast to the grid
- out_valid  out  1  bottom-of-array accumulate row valid this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at operation end
- err  out  1  sticky timeout flag; cleared on next accept
- step_idx  out  SW  current wavefront step (debug)

## Operation
- States: IDLE, LOAD, START, WAIT, SHIFT, DONE.
- IDLE: op_ready=1. On op_valid: latch M, clear err, load_cnt=0, step=0, go to LOAD.
- LOAD: weight_en=1 every cycle.
  - If weight_avail: assert weight_rd=1 and mac_shift=1, and increment load_cnt.
  - Else stall with no rd and no shift.
  - After the N-th shifted row: go to START if M>0, else to DONE.
- Step count S = M + 2N − 2, with step 0..S−1.
- START:
  - If step<M and !input_avail: stall with all strobes 0.
  - Otherwise: mac_start=1, input_rd=(step<M), wait_cnt=0, go to WAIT.
  - For step≥M, the external skew buffer zero-fills.
- WAIT:
  - If mac_value_ready: go to SHIFT.
  - Else increment wait_cnt.
  - If wait_cnt reaches TIMEOUT−1 without ready: set err=1 and go to DONE. No further shift or read occurs.
- SHIFT:
  - mac_shift=1.
  - out_valid=(step≥N−1), giving M+N−1 output beats per tile.
  - If step==S−1: go to DONE. Else step++ and go to START.
- DONE: done=1 for one cycle, then go to IDLE.
- weight_en=0 outside LOAD. mac_start, mac_shift, weight_rd, input_rd and out_valid are single-cycle strobes. mac_start and mac_shift are never high in the same cycle.
- Counters saturate-free: step never exceeds S−1, and load_cnt never exceeds N.

## Timing
- Reset: state=IDLE, all counters 0. Output values: op_ready=1, all other outputs 0 (including err and step_idx).
- RST mid-operation: the next cycle is IDLE. No done pulse. err clears.
- Accept at cycle t0. With avail and ready always high:
  - LOAD occupies t0+1..t0+N.
  - Each step is exactly 3 cycles (START, WAIT, SHIFT).
  - done is high at t0+N+1+3S.
- WAIT lasts at least 1 cycle. mac_value_ready is sampled in WAIT only; it is ignored in START and SHIFT.
- op_valid while busy is ignored; op_ready=0.
- M=0: LOAD then DONE. done at t0+N+1, with no mac_start.
- M=MAX_ROWS: S=MAX_ROWS+2N−2, which fits in SW bits.

## Test plan
- Basic tile, N=4, M=4, all avail/ready high:
  - 4 weight_rd/shift pulses with weight_en=1.
  - 10 mac_start, 4 input_rd, 10 mac_shift and 7 out_valid pulses (steps 3..9).
  - done at t0+35.
- Stalls: drop weight_avail for 3 cycles mid-LOAD and input_avail for 2 cycles at step 1.
  - No rd or shift occurs during the stalls.
  - done is delayed by exactly 5 cycles, and pulse counts are unchanged.
- Slow MAC: hold mac_value_ready low for 2 WAIT cycles per step, N=4, M=1 (S=7).
  - Each step takes 5 cycles; done at t0+5+35.
- Timeout, TIMEOUT=64: hold mac_value_ready low at step 2.
  - 64 WAIT cycles, then err=1 and a done pulse. No mac_shift after the stall.
  - err clears on the next accept.
- M=0 and back-to-back ops:
  - done at t0+5. A second op_valid held during busy is accepted the cycle after DONE.
  - step_idx restarts at 0.
- Reset mid-WAIT at step 5:
  - Next cycle: IDLE, busy=0, op_ready=1, no done pulse.
  - A subsequent op runs normally.
